// File: rtl/pipe_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_arb_pkg
// Description : Shared types and helpers for the pipe_arbiter block.
//               src_w   - index width for a given requester count.
//               rr_pick - round-robin selector with a per-source grant
//                         quantum; returns the chosen index and a hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_arb_pkg;

    // Upper bound on requester count handled by rr_pick.
    localparam int c_MAX_SRC   = 64;
    localparam int c_MAX_SRC_W = 6;

    typedef logic [c_MAX_SRC_W-1:0] src_idx_t;

    typedef struct packed {
        logic     hit;
        src_idx_t sel;
    } rr_pick_t;

    function automatic int src_w(input int num_src);
        return (num_src < 2) ? 1 : $clog2(num_src);
    endfunction

    // A source keeps the grant while its streak is shorter than the quantum
    // and it still has data. run == 0 means nothing has been granted since
    // reset, so there is no streak to continue and the scan starts at
    // last+1 (source 0 after reset). Otherwise scan last+1, last+2, ...
    // with last itself examined last, which keeps a lone source granted.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_SRC-1:0] valid,
        input src_idx_t             last,
        input int unsigned          run,
        input int unsigned          quantum,
        input int unsigned          num_src
    );
        rr_pick_t    r;
        int unsigned t;
        src_idx_t    idx;
        r.hit = 1'b0;
        r.sel = last;
        if (run != 0 && run < quantum && valid[last]) begin
            r.hit = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= c_MAX_SRC; k++) begin
                t   = (32'(last) + k) % num_src;
                idx = src_idx_t'(t);
                if (!r.hit && k <= num_src && valid[idx]) begin
                    r.hit = 1'b1;
                    r.sel = idx;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pipe_arb_rr_pick
// Description : Combinational round-robin / quantum source selector.
// Ports       : i_valid - per-source buffered-data flags
//               i_last  - index of the most recent grant
//               i_run   - consecutive grants given to i_last (0..QUANTUM)
//               o_sel   - selected source index
//               o_hit   - at least one source is valid
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_arb_rr_pick
    import pipe_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    parameter  int unsigned QUANTUM = 1,
    localparam int          SRC_W   = src_w(NUM_SRC),
    localparam int          RUN_W   = $clog2(QUANTUM + 1)
)(
    input  logic [NUM_SRC-1:0] i_valid,
    input  logic [SRC_W-1:0]   i_last,
    input  logic [RUN_W-1:0]   i_run,
    output logic [SRC_W-1:0]   o_sel,
    output logic               o_hit
);

    logic [c_MAX_SRC-1:0] w_valid_ext;
    src_idx_t             w_last_ext;
    rr_pick_t             w_pick;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[NUM_SRC-1:0] = i_valid;
        w_last_ext               = src_idx_t'(i_last);
        w_pick = rr_pick(w_valid_ext, w_last_ext, 32'(i_run), QUANTUM, NUM_SRC);
    end

    assign o_sel = SRC_W'(w_pick.sel);
    assign o_hit = w_pick.hit;

endmodule
`default_nettype wire

// File: rtl/pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_arbiter
// Description : Shares one enq pipe channel between NUM_SRC requesters.
//               One-entry input buffer per source, one-entry output buffer
//               tagged with the source index, round-robin arbitration with a
//               grant quantum, and a per-source accept mask.
// Ports       : CLK, RST      - clock, synchronous active-high reset
//               src_enq_*     - per-source enqueue (ENA/payload/RDY)
//               cfg_mask      - 1 blocks new accepts from that source
//               out_enq_*     - shared pipe enqueue (ENA/payload/src/RDY)
//               idle          - both buffer stages empty
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_arbiter
    import pipe_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 192,
    parameter  int unsigned NUM_SRC    = 4,
    parameter  int unsigned QUANTUM    = 1,
    localparam int          SRC_W      = src_w(NUM_SRC)
)(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_SRC-1:0]            src_enq__ENA,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_enq_v,
    output logic [NUM_SRC-1:0]            src_enq__RDY,
    input  logic [NUM_SRC-1:0]            cfg_mask,
    output logic                          out_enq__ENA,
    output logic [DATA_WIDTH-1:0]         out_enq_v,
    output logic [SRC_W-1:0]              out_enq_src,
    input  logic                          out_enq__RDY,
    output logic                          idle
);

    localparam int c_RUN_W = $clog2(QUANTUM + 1);

    logic [NUM_SRC-1:0]    w_ibuf_valid;
    logic [DATA_WIDTH-1:0] w_ibuf_data [NUM_SRC];
    logic [NUM_SRC-1:0]    w_accept;
    logic [NUM_SRC-1:0]    w_take;

    logic                  r_obuf_valid;
    logic [DATA_WIDTH-1:0] r_obuf_data;
    logic [SRC_W-1:0]      r_obuf_src;
    logic [SRC_W-1:0]      r_last;
    logic [c_RUN_W-1:0]    r_run;

    logic [SRC_W-1:0]      w_sel;
    logic                  w_hit;
    logic                  w_room;
    logic                  w_move;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    pipe_arb_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .QUANTUM (QUANTUM)
    ) u_pick (
        .i_valid (w_ibuf_valid),
        .i_last  (r_last),
        .i_run   (r_run),
        .o_sel   (w_sel),
        .o_hit   (w_hit)
    );

    // The output buffer can take a new entry if empty or draining now.
    assign w_room = ~r_obuf_valid | out_enq__RDY;
    // w_hit is set exactly when any input buffer holds data.
    assign w_move = w_room & w_hit;

    // ------------------------------------------------------------------
    // Input buffers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic                  r_valid;
        logic [DATA_WIDTH-1:0] r_data;

        assign w_take[i] = w_move & (w_sel == SRC_W'(i));
        // RDY only looks at state, mask and the move decision, never at ENA.
        assign src_enq__RDY[i] = ~cfg_mask[i] & (~r_valid | w_take[i]);
        // An ENA without RDY is a protocol violation and is dropped.
        assign w_accept[i]     = src_enq__ENA[i] & src_enq__RDY[i];

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_accept[i]) begin
                r_valid <= 1'b1;
                r_data  <= src_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_take[i]) begin
                r_valid <= 1'b0;
            end
        end

        assign w_ibuf_valid[i] = r_valid;
        assign w_ibuf_data[i]  = r_data;
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_obuf_valid <= 1'b0;
            r_obuf_data  <= '0;
            r_obuf_src   <= '0;
        end else if (w_move) begin
            r_obuf_valid <= 1'b1;
            r_obuf_data  <= w_ibuf_data[w_sel];
            r_obuf_src   <= w_sel;
        end else if (out_enq__ENA) begin
            r_obuf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Grant history: last winner and saturating streak length
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= SRC_W'(NUM_SRC - 1);
            r_run  <= '0;
        end else if (w_move) begin
            if (w_sel == r_last) begin
                if (r_run != c_RUN_W'(QUANTUM)) begin
                    r_run <= r_run + 1'b1;
                end
            end else begin
                r_last <= w_sel;
                r_run  <= c_RUN_W'(1);
            end
        end
    end

    assign out_enq__ENA = r_obuf_valid & out_enq__RDY;
    assign out_enq_v    = r_obuf_data;
    assign out_enq_src  = r_obuf_src;
    assign idle         = ~r_obuf_valid & ~(|w_ibuf_valid);

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_arbiter
// Description : Self-checking bench for pipe_arbiter. Instance 0 uses
//               QUANTUM=1, instance 1 uses QUANTUM=3; both 4 sources x 16 b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_arbiter;

    localparam int c_DW = 16;

    logic        clk;
    logic        rst    [2];
    logic [3:0]  s_ena  [2];
    logic [63:0] s_v    [2];
    logic [3:0]  s_rdy  [2];
    logic [3:0]  mask   [2];
    logic        o_ena  [2];
    logic [15:0] o_v    [2];
    logic [1:0]  o_src  [2];
    logic        o_rdy  [2];
    logic        idle   [2];

    int checks = 0;
    int errors = 0;

    logic [11:0] seq_in  [4];
    logic [11:0] seq_out [4];
    int          out_k;

    pipe_arbiter #(.DATA_WIDTH(c_DW), .NUM_SRC(4), .QUANTUM(1)) u_dut_q1 (
        .CLK(clk), .RST(rst[0]),
        .src_enq__ENA(s_ena[0]), .src_enq_v(s_v[0]), .src_enq__RDY(s_rdy[0]),
        .cfg_mask(mask[0]),
        .out_enq__ENA(o_ena[0]), .out_enq_v(o_v[0]), .out_enq_src(o_src[0]),
        .out_enq__RDY(o_rdy[0]), .idle(idle[0])
    );

    pipe_arbiter #(.DATA_WIDTH(c_DW), .NUM_SRC(4), .QUANTUM(3)) u_dut_q3 (
        .CLK(clk), .RST(rst[1]),
        .src_enq__ENA(s_ena[1]), .src_enq_v(s_v[1]), .src_enq__RDY(s_rdy[1]),
        .cfg_mask(mask[1]),
        .out_enq__ENA(o_ena[1]), .out_enq_v(o_v[1]), .out_enq_src(o_src[1]),
        .out_enq__RDY(o_rdy[1]), .idle(idle[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic [3:0]  ena;
        logic [15:0] d;
        logic [3:0]  mask;
        logic        ordy;
        logic        exp_ena;
        logic [1:0]  exp_src;
        logic [15:0] exp_v;
        logic [3:0]  exp_rdy;
        logic        exp_idle;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic [15:0] d,
                                input logic [3:0] m, input logic ordy, input logic xe,
                                input logic [1:0] xs, input logic [15:0] xv,
                                input logic [3:0] xr, input logic xi);
        vec_t v;
        v.rst = r; v.ena = e; v.d = d; v.mask = m; v.ordy = ordy;
        v.exp_ena = xe; v.exp_src = xs; v.exp_v = xv; v.exp_rdy = xr; v.exp_idle = xi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int inst);
        @(negedge clk);
        rst[inst]   = 1'b1;
        s_ena[inst] = 4'h0;
        mask[inst]  = 4'h0;
        o_rdy[inst] = 1'b1;
        @(negedge clk);
        rst[inst] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq_in[i]  = 12'd0;
            seq_out[i] = 12'd0;
        end
        out_k = 0;
    endtask

    // One cycle: offer data on every active source whose RDY is high.
    task automatic drive_cycle(input int inst, input logic [3:0] active,
                               input logic ordy, output logic [3:0] acc);
        @(negedge clk);
        o_rdy[inst] = ordy;
        #1;
        acc = active & s_rdy[inst];
        for (int i = 0; i < 4; i++) begin
            s_v[inst][i*c_DW +: c_DW] = {4'(i), seq_in[i]};
            if (acc[i]) seq_in[i] = seq_in[i] + 12'd1;
        end
        s_ena[inst] = acc;
        #1;
    endtask

    task automatic check_out(input int inst, input int exp_src);
        if (o_ena[inst]) begin
            chk("out_src", 64'(o_src[inst]), 64'(exp_src));
            chk("out_v", 64'(o_v[inst]), 64'({4'(exp_src), seq_out[exp_src]}));
            seq_out[exp_src] = seq_out[exp_src] + 12'd1;
            out_k++;
        end
    endtask

    task automatic run_stream(input int inst, input logic [3:0] active, input int q,
                              input int single, input int ncyc);
        logic [3:0] acc;
        int         exp_src;
        for (int t = 0; t < ncyc; t++) begin
            drive_cycle(inst, active, 1'b1, acc);
            if (t >= 2) chk("stream_ena", 64'(o_ena[inst]), 64'd1);
            exp_src = (single >= 0) ? single : (out_k / q) % 4;
            check_out(inst, exp_src);
        end
    endtask

    logic [3:0] acc;
    int         total;
    int         bp_order [5];

    initial begin
        for (int n = 0; n < 2; n++) begin
            rst[n] = 1'b1; s_ena[n] = 4'h0; s_v[n] = '0; mask[n] = 4'h0; o_rdy[n] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            seq_in[i] = 12'd0; seq_out[i] = 12'd0;
        end
        out_k = 0;

        //         rst ena    d        mask  ordy  ena src  v        rdy    idle
        tbl[0]  = mk(1, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd0, 16'h0000, 4'hF, 1);
        tbl[1]  = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd0, 16'h0000, 4'hF, 1);
        tbl[2]  = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd0, 16'h0000, 4'hF, 1);
        tbl[3]  = mk(0, 4'h4, 16'h00A5, 4'h0, 1,   0, 2'd0, 16'h0000, 4'hF, 1);
        tbl[4]  = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd0, 16'h0000, 4'hF, 0);
        tbl[5]  = mk(0, 4'h0, 16'h0000, 4'h0, 1,   1, 2'd2, 16'h00A5, 4'hF, 0);
        tbl[6]  = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd2, 16'h00A5, 4'hF, 1);
        tbl[7]  = mk(0, 4'h2, 16'h1111, 4'h0, 1,   0, 2'd2, 16'h00A5, 4'hF, 1);
        tbl[8]  = mk(0, 4'h0, 16'h0000, 4'h2, 1,   0, 2'd2, 16'h00A5, 4'hD, 0);
        tbl[9]  = mk(0, 4'h0, 16'h0000, 4'h2, 1,   1, 2'd1, 16'h1111, 4'hD, 0);
        tbl[10] = mk(0, 4'h0, 16'h0000, 4'h2, 1,   0, 2'd1, 16'h1111, 4'hD, 1);
        tbl[11] = mk(0, 4'h0, 16'h0000, 4'h2, 0,   0, 2'd1, 16'h1111, 4'hD, 1);
        tbl[12] = mk(0, 4'h1, 16'h0101, 4'h0, 1,   0, 2'd1, 16'h1111, 4'hF, 1);
        tbl[13] = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd1, 16'h1111, 4'hF, 0);
        tbl[14] = mk(0, 4'h1, 16'h0202, 4'h0, 0,   0, 2'd0, 16'h0101, 4'hF, 0);
        tbl[15] = mk(0, 4'h0, 16'h0000, 4'h0, 0,   0, 2'd0, 16'h0101, 4'hE, 0);
        tbl[16] = mk(0, 4'h0, 16'h0000, 4'h0, 1,   1, 2'd0, 16'h0101, 4'hF, 0);
        tbl[17] = mk(0, 4'h0, 16'h0000, 4'h0, 1,   1, 2'd0, 16'h0202, 4'hF, 0);
        tbl[18] = mk(0, 4'h0, 16'h0000, 4'h0, 1,   0, 2'd0, 16'h0202, 4'hF, 1);

        // Directed vectors: reset state, single source latency, mask, backpressure.
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            rst[0]   = tbl[k].rst;
            mask[0]  = tbl[k].mask;
            o_rdy[0] = tbl[k].ordy;
            s_v[0]   = {4{tbl[k].d}};
            s_ena[0] = tbl[k].ena;
            #1;
            if (|(tbl[k].ena & ~s_rdy[0])) begin
                errors++;
                $display("FAIL vec%0d_protocol: ena %0h while rdy %0h", k, tbl[k].ena, s_rdy[0]);
            end
            chk($sformatf("vec%0d_ena", k),  64'(o_ena[0]), 64'(tbl[k].exp_ena));
            chk($sformatf("vec%0d_src", k),  64'(o_src[0]), 64'(tbl[k].exp_src));
            chk($sformatf("vec%0d_v", k),    64'(o_v[0]),   64'(tbl[k].exp_v));
            chk($sformatf("vec%0d_rdy", k),  64'(s_rdy[0]), 64'(tbl[k].exp_rdy));
            chk($sformatf("vec%0d_idle", k), 64'(idle[0]),  64'(tbl[k].exp_idle));
        end

        // Round robin, quantum 1: 0,1,2,3,... one payload per cycle.
        do_reset(0);
        run_stream(0, 4'hF, 1, -1, 20);

        // Quantum 3: 0,0,0,1,1,1,...; then a lone source 1 every cycle.
        do_reset(1);
        run_stream(1, 4'hF, 3, -1, 26);
        do_reset(1);
        run_stream(1, 4'b0010, 3, 1, 10);

        // Backpressure: five payloads held, then drained back to back.
        do_reset(0);
        total = 0;
        for (int t = 0; t < 10; t++) begin
            drive_cycle(0, 4'hF, 1'b0, acc);
            total += $countones(acc);
            chk("bp_hold_ena", 64'(o_ena[0]), 64'd0);
        end
        chk("bp_rdy", 64'(s_rdy[0]), 64'd0);
        chk("bp_idle", 64'(idle[0]), 64'd0);
        chk("bp_count", 64'(total), 64'd5);
        bp_order = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 6; t++) begin
            drive_cycle(0, 4'h0, 1'b1, acc);
            chk("bp_drain_ena", 64'(o_ena[0]), (t < 5) ? 64'd1 : 64'd0);
            if (t < 5) check_out(0, bp_order[t]);
        end
        chk("bp_idle_end", 64'(idle[0]), 64'd1);

        // Reset with obuf and three ibufs full.
        do_reset(0);
        @(negedge clk);
        o_rdy[0] = 1'b0; s_v[0] = {16'h3333, 16'h2222, 16'h1111, 16'h0000}; s_ena[0] = 4'hF;
        @(negedge clk);
        s_ena[0] = 4'h0;
        @(negedge clk);
        #1;
        chk("mid_full_idle", 64'(idle[0]), 64'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0; o_rdy[0] = 1'b1;
        #1;
        chk("mid_post_ena", 64'(o_ena[0]), 64'd0);
        chk("mid_post_idle", 64'(idle[0]), 64'd1);
        chk("mid_post_v", 64'(o_v[0]), 64'd0);
        chk("mid_post_src", 64'(o_src[0]), 64'd0);
        chk("mid_post_rdy", 64'(s_rdy[0]), 64'hF);
        s_v[0] = {16'h7003, 16'h7002, 16'h7001, 16'h7000}; s_ena[0] = 4'hF;
        @(negedge clk);
        s_ena[0] = 4'h0;
        #1;
        chk("mid_grant_rdy", 64'(s_rdy[0]), 64'h1);
        chk("mid_grant_ena0", 64'(o_ena[0]), 64'd0);
        @(negedge clk);
        #1;
        chk("mid_first_ena", 64'(o_ena[0]), 64'd1);
        chk("mid_first_src", 64'(o_src[0]), 64'd0);
        chk("mid_first_v", 64'(o_v[0]), 64'h7000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
